// File: rtl/core_pkg.sv
// Shared core types: default datapath widths and the fetch tag that follows
// each instruction-memory request until its response returns.
package core_pkg;

  localparam int Xlen     = 64;
  localparam int Ilen     = 32;
  localparam int MaskBits = Xlen / 8;

  typedef struct packed {
    logic [Xlen-1:0] pc;
    logic            epoch;
  } fetch_tag_t;

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with a flush input.
// Flush takes priority over push and pop in the same cycle.
module fifo #(
  parameter int Width     = 8,
  parameter int DepthLog2 = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [Width-1:0]   wdata_i,
  input  logic               pop_i,
  output logic [Width-1:0]   rdata_o,
  output logic               empty_o,
  output logic [DepthLog2:0] count_o
);

  localparam int Depth = 1 << DepthLog2;
  localparam int CntW  = DepthLog2 + 1;

  logic [Width-1:0]     mem_q [Depth];
  logic [DepthLog2-1:0] wr_ptr_q;
  logic [DepthLog2-1:0] rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 full_s;
  logic                 do_push_s;
  logic                 do_pop_s;

  assign full_s    = (count_q == CntW'(Depth));
  assign empty_o   = (count_q == '0);
  assign do_push_s = push_i && !full_s && !flush_i;
  assign do_pop_s  = pop_i && !empty_o && !flush_i;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + DepthLog2'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + DepthLog2'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, in-order tag queue and
// epoch-based squash on redirect. Define FETCH_STATS_EN for fetch/squash counters.
module fetch_unit #(
  parameter int              Xlen           = core_pkg::Xlen,
  parameter int              Ilen           = core_pkg::Ilen,
  parameter int              DepthLog2      = 2,
  parameter int              MaxOutstanding = 2,
  parameter logic [Xlen-1:0] ResetPc        = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_valid_i,
  input  logic [Xlen-1:0]   redirect_pc_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [Xlen-1:0]   inst_pc_o,
  output logic [Ilen-1:0]   inst_data_o,
  input  logic              instmem_ready_i,
  output logic              instmem_valid_o,
  output logic [Xlen-1:0]   instmem_addr_o,
  output logic [Xlen-1:0]   instmem_wdata_o,
  output logic [Xlen/8-1:0] instmem_wmask_o,
  input  logic [Xlen-1:0]   instmem_rdata_i,
  input  logic              instmem_rvalid_i
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       fetched_cnt_o,
  output logic [31:0]       squashed_cnt_o
`endif
);

  import core_pkg::*;

  localparam int Depth  = 1 << DepthLog2;
  localparam int PtrW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int OutW   = $clog2(MaxOutstanding + 1);
  localparam int TagPcW = $bits(fetch_tag_t) - 1;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) begin
      return '0;
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  fetch_tag_t           tag_q [MaxOutstanding];
  logic [Xlen-1:0]      fetch_pc_q, fetch_pc_d;
  logic                 epoch_q, epoch_d;
  logic [PtrW-1:0]      tag_wr_q, tag_wr_d;
  logic [PtrW-1:0]      tag_rd_q, tag_rd_d;
  logic [OutW-1:0]      outst_q, outst_d;
  logic [Xlen-1:0]      target_s;
  logic [Xlen-1:0]      tag_pc_s;
  logic                 tag_epoch_s;
  logic                 credit_s, issue_s, rsp_s, accept_s, squash_s;
  logic [Ilen-1:0]      inst_sel_s;
  logic [DepthLog2:0]   buf_cnt_s;
  logic                 buf_empty_s;
  logic [Xlen+Ilen-1:0] buf_rdata_s;
  logic                 unused_s;

  assign target_s        = {redirect_pc_i[Xlen-1:2], 2'b00};
  assign tag_pc_s        = Xlen'(tag_q[tag_rd_q].pc);
  assign tag_epoch_s     = tag_q[tag_rd_q].epoch;
  assign instmem_valid_o = credit_s && !rst_i;
  assign instmem_addr_o  = redirect_valid_i ? target_s : fetch_pc_q;
  assign instmem_wdata_o = '0;
  assign instmem_wmask_o = '0;
  assign issue_s         = instmem_valid_o && instmem_ready_i;
  assign rsp_s           = instmem_rvalid_i && (outst_q != '0);
  assign accept_s        = rsp_s && !redirect_valid_i && (tag_epoch_s == epoch_q);
  assign squash_s        = rsp_s && !accept_s;
  assign inst_sel_s      = (Xlen == 64 && tag_pc_s[2]) ? Ilen'(instmem_rdata_i >> 6'd32)
                                                       : Ilen'(instmem_rdata_i);
  assign unused_s        = ^redirect_pc_i[1:0];

  // Credit check and next-state; a redirect empties the buffer, so its occupancy stops counting.
  always_comb begin
    int occ;
    occ        = redirect_valid_i ? 0 : int'(buf_cnt_s);
    credit_s   = (int'(outst_q) < MaxOutstanding) && ((int'(outst_q) + occ) < Depth);
    epoch_d    = epoch_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid_i) begin
      epoch_d    = ~epoch_q;
      fetch_pc_d = issue_s ? (target_s + Xlen'(4)) : target_s;
    end else if (issue_s) begin
      fetch_pc_d = fetch_pc_q + Xlen'(4);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
    tag_wr_d = issue_s ? ptr_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d = rsp_s ? ptr_inc(tag_rd_q) : tag_rd_q;
    case ({issue_s, rsp_s})
      2'b10:   outst_d = outst_q + OutW'(1);
      2'b01:   outst_d = outst_q - OutW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= {ResetPc[Xlen-1:2], 2'b00};
      epoch_q    <= 1'b0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      outst_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      epoch_q    <= epoch_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      outst_q    <= outst_d;
    end
  end

  // A request issued during a redirect already belongs to the new epoch.
  always_ff @(posedge clk_i) begin
    if (issue_s) tag_q[tag_wr_q] <= '{pc: TagPcW'(instmem_addr_o), epoch: epoch_d};
  end

  fifo #(
    .Width     (Xlen + Ilen),
    .DepthLog2 (DepthLog2)
  ) u_ibuf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_valid_i),
    .push_i  (accept_s),
    .wdata_i ({tag_pc_s, inst_sel_s}),
    .pop_i   (inst_ready_i),
    .rdata_o (buf_rdata_s),
    .empty_o (buf_empty_s),
    .count_o (buf_cnt_s)
  );

  assign inst_valid_o = !buf_empty_s;
  assign inst_pc_o    = buf_rdata_s[Xlen+Ilen-1:Ilen];
  assign inst_data_o  = buf_rdata_s[Ilen-1:0];

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_cnt_q;
  logic [31:0] squashed_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetched_cnt_q  <= 32'd0;
      squashed_cnt_q <= 32'd0;
    end else begin
      if (accept_s) fetched_cnt_q  <= fetched_cnt_q + 32'd1;
      if (squash_s) squashed_cnt_q <= squashed_cnt_q + 32'd1;
    end
  end

  assign fetched_cnt_o  = fetched_cnt_q;
  assign squashed_cnt_o = squashed_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default parameters, Xlen=64).
// Counter checks are compiled in only when FETCH_STATS_EN is defined.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_valid_i = 1'b0;
  logic [63:0] redirect_pc_i = 64'd0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [63:0] inst_pc_o;
  logic [31:0] inst_data_o;
  logic        instmem_ready_i = 1'b0;
  logic        instmem_valid_o;
  logic [63:0] instmem_addr_o;
  logic [63:0] instmem_wdata_o;
  logic [7:0]  instmem_wmask_o;
  logic [63:0] instmem_rdata_i = 64'd0;
  logic        instmem_rvalid_i = 1'b0;
`ifdef FETCH_STATS_EN
  logic [31:0] fetched_cnt_o;
  logic [31:0] squashed_cnt_o;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          acc_cnt = 0;
  int          n_pre;
  bit          auto_rsp = 1'b1;
  logic [63:0] stall_at = '1;
  logic [63:0] mem_q [$];
  logic [63:0] got_pc [$];
  logic [31:0] got_data [$];

  fetch_unit dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_pc_o        (inst_pc_o),
    .inst_data_o      (inst_data_o),
    .instmem_ready_i  (instmem_ready_i),
    .instmem_valid_o  (instmem_valid_o),
    .instmem_addr_o   (instmem_addr_o),
    .instmem_wdata_o  (instmem_wdata_o),
    .instmem_wmask_o  (instmem_wmask_o),
    .instmem_rdata_i  (instmem_rdata_i),
    .instmem_rvalid_i (instmem_rvalid_i)
`ifdef FETCH_STATS_EN
    ,
    .fetched_cnt_o    (fetched_cnt_o),
    .squashed_cnt_o   (squashed_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] word_at(input logic [63:0] pc);
    return {16'h1357, pc[15:0]};
  endfunction

  function automatic logic [63:0] line_at(input logic [63:0] a);
    logic [63:0] base;
    base = {a[63:3], 3'b000};
    return {word_at(base + 64'd4), word_at(base)};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes, cross the edge, then let the memory model answer.
  task automatic cycle();
    logic        acc;
    logic [63:0] a;
    #1;
    acc = instmem_valid_o && instmem_ready_i && !rst_i;
    a   = instmem_addr_o;
    if (inst_valid_o && inst_ready_i && !rst_i && !redirect_valid_i) begin
      got_pc.push_back(inst_pc_o);
      got_data.push_back(inst_data_o);
    end
    @(posedge clk_i);
    if (acc) begin
      mem_q.push_back(a);
      acc_cnt++;
    end
    #1;
    if (auto_rsp) begin
      if (mem_q.size() > 0 && mem_q[0] < stall_at) begin
        instmem_rvalid_i = 1'b1;
        instmem_rdata_i  = line_at(mem_q.pop_front());
      end else begin
        instmem_rvalid_i = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_i            = 1'b1;
    redirect_valid_i = 1'b0;
    instmem_rvalid_i = 1'b0;
    auto_rsp         = 1'b1;
    stall_at         = '1;
    mem_q.delete();
    got_pc.delete();
    got_data.delete();
    acc_cnt = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(posedge clk_i);
    #1;
    check_eq("rst_inst_valid", inst_valid_o, 64'd0);
    check_eq("rst_mem_valid", instmem_valid_o, 64'd0);
    check_eq("rst_wdata", instmem_wdata_o, 64'd0);
    check_eq("rst_wmask", instmem_wmask_o, 64'd0);
`ifdef FETCH_STATS_EN
    check_eq("rst_fetched", fetched_cnt_o, 64'd0);
    check_eq("rst_squashed", squashed_cnt_o, 64'd0);
`endif

    // Streaming fetch: addresses 0,4,8,C and one-cycle response-to-valid latency
    do_reset();
    inst_ready_i    = 1'b1;
    instmem_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t1_addr", instmem_addr_o, 64'(i * 4));
      check_eq("t1_req_valid", instmem_valid_o, 64'd1);
      check_eq("t1_inst_valid", inst_valid_o, (i >= 2) ? 64'd1 : 64'd0);
      check_eq("t1_wmask", instmem_wmask_o, 64'd0);
      cycle();
    end
    repeat (3) cycle();
    check_eq("t1_got_count", (got_pc.size() >= 4) ? 64'd1 : 64'd0, 64'd1);
    for (int i = 0; i < 4; i++) begin
      check_eq("t1_pc", got_pc[i], 64'(i * 4));
      check_eq("t1_data", got_data[i], word_at(64'(i * 4)));
    end

    // Decode stalled: buffer fills to 4, requests stop, nothing lost on resume
    do_reset();
    inst_ready_i = 1'b0;
    repeat (8) cycle();
    #1;
    check_eq("t2_accepted", acc_cnt, 64'd4);
    check_eq("t2_req_valid", instmem_valid_o, 64'd0);
    check_eq("t2_inst_valid", inst_valid_o, 64'd1);
    check_eq("t2_hold_pc", inst_pc_o, 64'd0);
    check_eq("t2_hold_data", inst_data_o, word_at(64'd0));
    inst_ready_i = 1'b1;
    repeat (12) cycle();
    check_eq("t2_got_count", (got_pc.size() >= 8) ? 64'd1 : 64'd0, 64'd1);
    for (int i = 0; i < 8; i++) begin
      check_eq("t2_pc", got_pc[i], 64'(i * 4));
    end

    // Redirect with 0x10 and 0x14 in flight
    do_reset();
    inst_ready_i = 1'b1;
    stall_at     = 64'h10;
    repeat (8) cycle();
    #1;
    check_eq("t3_credit", instmem_valid_o, 64'd0);
    check_eq("t3_inflight", mem_q.size(), 64'd2);
    check_eq("t3_inflight0", mem_q[0], 64'h10);
    check_eq("t3_inflight1", mem_q[1], 64'h14);
    n_pre = got_pc.size();
    check_eq("t3_pre_count", n_pre, 64'd4);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h103;
    #1;
    check_eq("t3_bypass_addr", instmem_addr_o, 64'h100);
    cycle();
    redirect_valid_i = 1'b0;
    stall_at         = '1;
    #1;
    check_eq("t3_flushed", inst_valid_o, 64'd0);
    check_eq("t3_addr_next", instmem_addr_o, 64'h100);
    repeat (8) cycle();
    check_eq("t3_first_pc", got_pc[n_pre], 64'h100);
    check_eq("t3_first_data", got_data[n_pre], word_at(64'h100));
`ifdef FETCH_STATS_EN
    check_eq("t3_squashed", squashed_cnt_o, 64'd2);
`endif

    // Redirect coincident with a response and a decode pop
    do_reset();
    inst_ready_i = 1'b1;
    repeat (4) cycle();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h200;
    #1;
    check_eq("t4_pre_inst_valid", inst_valid_o, 64'd1);
    check_eq("t4_addr", instmem_addr_o, 64'h200);
    check_eq("t4_req_valid", instmem_valid_o, 64'd1);
    cycle();
    redirect_valid_i = 1'b0;
    #1;
    check_eq("t4_inst_valid", inst_valid_o, 64'd0);
    check_eq("t4_addr_next", instmem_addr_o, 64'h204);
    cycle();
    #1;
    check_eq("t4_new_valid", inst_valid_o, 64'd1);
    check_eq("t4_new_pc", inst_pc_o, 64'h200);
    check_eq("t4_new_data", inst_data_o, word_at(64'h200));
`ifdef FETCH_STATS_EN
    check_eq("t4_squashed", squashed_cnt_o, 64'd1);
    check_eq("t4_fetched", fetched_cnt_o, 64'd4);
`endif

    // Reset with two requests outstanding, stale responses afterwards
    do_reset();
    inst_ready_i = 1'b1;
    stall_at     = 64'h8;
    repeat (6) cycle();
    #1;
    check_eq("t5_inflight", mem_q.size(), 64'd2);
    rst_i    = 1'b1;
    auto_rsp = 1'b0;
    mem_q.delete();
    instmem_rvalid_i = 1'b0;
    #1;
    check_eq("t5_rst_inst_valid", inst_valid_o, 64'd0);
    check_eq("t5_rst_req_valid", instmem_valid_o, 64'd0);
    cycle();
    got_pc.delete();
    got_data.delete();
    rst_i           = 1'b0;
    instmem_ready_i = 1'b0;
    #1;
    check_eq("t5_first_valid", instmem_valid_o, 64'd1);
    check_eq("t5_first_addr", instmem_addr_o, 64'd0);
    instmem_rvalid_i = 1'b1;
    instmem_rdata_i  = line_at(64'h8);
    cycle();
    cycle();
    instmem_rvalid_i = 1'b0;
    #1;
    check_eq("t5_stale_valid0", inst_valid_o, 64'd0);
    cycle();
    #1;
    check_eq("t5_stale_valid1", inst_valid_o, 64'd0);
    check_eq("t5_addr_held", instmem_addr_o, 64'd0);
`ifdef FETCH_STATS_EN
    check_eq("t5_squashed", squashed_cnt_o, 64'd0);
    check_eq("t5_fetched", fetched_cnt_o, 64'd0);
`endif
    instmem_ready_i = 1'b1;
    auto_rsp        = 1'b1;
    stall_at        = '1;
    repeat (5) cycle();
    check_eq("t5_resume_pc0", got_pc[0], 64'd0);
    check_eq("t5_resume_pc1", got_pc[1], 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter Xlen, default 64, data/address width; legal values 32 and 64.
REQ-002 SHALL have parameter Ilen, default 32, instruction width.
REQ-003 SHALL have parameter DepthLog2, default 2, log2 of instruction buffer entries.
REQ-004 SHALL have parameter MaxOutstanding, default 2, max in-flight fetch requests, 1..8.
REQ-005 SHALL have parameter ResetPc, default 0, first fetch address.
REQ-006 SHALL have ports, in order: clk_i in 1 clock; rst_i in 1 reset. One clock; reset is asynchronous and active-high.
REQ-007 SHALL have redirect_valid_i in 1 (jump/branch taken) and redirect_pc_i in Xlen (target).
REQ-008 SHALL have inst_valid_o out 1, inst_ready_i in 1, inst_pc_o out Xlen, inst_data_o out Ilen (decode handshake).
REQ-009 SHALL have instmem_ready_i in 1, instmem_valid_o out 1, instmem_addr_o out Xlen, instmem_wdata_o out Xlen, instmem_wmask_o out MaskBits, instmem_rdata_i in Xlen, instmem_rvalid_i in 1.

Function
REQ-010 SHALL issue a request in any cycle with instmem_valid_o && instmem_ready_i; instmem_wdata_o and instmem_wmask_o SHALL be constant 0.
REQ-011 SHALL assert instmem_valid_o only when outstanding < MaxOutstanding and outstanding + buffer occupancy < 2**DepthLog2 (credit rule; buffer can never overflow).
REQ-012 SHALL advance fetch PC by 4 per accepted request; address bits [1:0] always 0.
REQ-013 SHALL record per request {pc, epoch} in an in-order tag queue, MaxOutstanding deep; responses are in order.
REQ-014 On instmem_rvalid_i SHALL pop one tag; Xlen=64: pc[2]=0 selects rdata[31:0], else rdata[63:32]; Xlen=32: whole rdata.
REQ-015 SHALL write {pc, instruction} into the buffer only if tag epoch equals current epoch; otherwise discard (squash).
REQ-016 SHALL present buffer head on inst_*_o; pop on inst_valid_o && inst_ready_i; response in cycle N visible at inst_valid_o in N+1.
REQ-017 On redirect_valid_i: flip epoch, clear buffer, set fetch PC to {redirect_pc_i[Xlen-1:2],2'b00}, all same cycle.
REQ-018 In a redirect cycle instmem_addr_o SHALL bypass to the aligned redirect target; if accepted, fetch PC becomes target+4.
REQ-019 Redirect with rvalid same cycle: that response SHALL be squashed.
REQ-020 Redirect with inst_ready_i same cycle: pop ignored, buffer empty next cycle, inst_valid_o=0.
REQ-021 rvalid with empty tag queue SHALL be ignored (no state change).
REQ-022 Buffer full or credit exhausted: instmem_valid_o=0; no request dropped; inst_* held stable while inst_valid_o && !inst_ready_i.

Reset
REQ-023 On rst_i: fetch PC=ResetPc, epoch=0, tag queue and buffer empty, inst_valid_o=0, instmem_valid_o=0, counters 0.
REQ-024 Reset mid-operation SHALL abandon in-flight requests; later responses fall under REQ-021.
REQ-025 First request SHALL issue in the first cycle after rst_i deasserts, addr=ResetPc.

Configuration
REQ-026 Macro FETCH_STATS_EN defined: outputs fetched_cnt_o (32, out, instructions written to buffer) and squashed_cnt_o (32, out, discarded responses), wrapping modulo 2**32.
REQ-027 Macro FETCH_STATS_EN undefined: these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-028 Xlen, Ilen, MaskBits and a fetch_tag_t struct {pc, epoch} SHALL live in core_pkg.
REQ-029 Instruction buffer SHALL be an instance of the existing fifo module (Width=Xlen+Ilen); tag queue and credit logic SHALL be local.

Verification
REQ-030 Reset, ready always 1, rvalid 1 cycle later: addresses 0,4,8,C; inst_pc_o 0,4,8,C in order; Xlen=64 half select correct.
REQ-031 inst_ready_i=0: exactly 4 instructions buffered (DepthLog2=2), instmem_valid_o=0 thereafter, no loss on resume.
REQ-032 Two requests (0x10,0x14) in flight, redirect to 0x103: addr 0x100 same cycle, both old responses squashed, next inst_pc_o=0x100, squashed_cnt_o=2.
REQ-033 Redirect coincident with rvalid and inst_ready_i: response squashed, inst_valid_o=0 next cycle.
REQ-034 rst_i asserted with 2 outstanding, then 2 stale rvalids: ignored, inst_valid_o stays 0, first fetch addr=ResetPc.
REQ-035 Build without FETCH_STATS_EN: REQ-030..033 traces identical.
